// File: rtl/sprite_compositor.sv
// sprite_compositor: priority-composites NUM_SPRITES rectangles into an RRRGGGBB pixel and flags per-frame player collisions
// Ports: i_clk/i_rst (sync, active high); i_pix_stb advances the 2-stage pipeline; i_animate closes a frame;
//   i_blank/i_x/i_y describe the current pixel; i_rects {y2,y1,x2,x1} per sprite, i_colors, i_enable per sprite;
//   o_color/o_valid composited pixel; o_collide/o_collide_cnt collision result and saturating frame count.
// Optional: define SPRITE_BORDER_EN to draw the inner edge of the winning sprite in BORDER_COLOR.
module sprite_compositor #(
  parameter int NUM_SPRITES = 4,
  parameter int COORD_W = 12,
  parameter int COLOR_W = 8,
  parameter int CNT_W = 8,
  parameter logic [COLOR_W-1:0] BG_COLOR = '0,
  parameter logic [NUM_SPRITES-1:0] COLLIDE_MASK = ~NUM_SPRITES'(1)
`ifdef SPRITE_BORDER_EN
  ,
  parameter logic [COLOR_W-1:0] BORDER_COLOR = '1
`endif
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_pix_stb,
  input  logic                           i_animate,
  input  logic                           i_blank,
  input  logic [9:0]                     i_x,
  input  logic [8:0]                     i_y,
  input  logic [NUM_SPRITES*4*COORD_W-1:0] i_rects,
  input  logic [NUM_SPRITES*COLOR_W-1:0] i_colors,
  input  logic [NUM_SPRITES-1:0]         i_enable,
  output logic [COLOR_W-1:0]             o_color,
  output logic                           o_valid,
  output logic                           o_collide,
  output logic [CNT_W-1:0]               o_collide_cnt
);
  logic signed [COORD_W-1:0] px, py, x1, x2, y1, y2;
  logic [NUM_SPRITES-1:0] cov, hit_d, hit_q;
  logic blank_d, blank_q, valid_d, valid_q, sticky_d, sticky_q, collide_d, collide_q, coll, frame_hit;
  logic [COLOR_W-1:0] win_col, color_d, color_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
`ifdef SPRITE_BORDER_EN
  logic bord, edge_d, edge_q;
`endif
  always_comb begin
    px = $signed(COORD_W'(i_x));
    py = $signed(COORD_W'(i_y));
    x1 = '0;
    x2 = '0;
    y1 = '0;
    y2 = '0;
    cov = '0;
`ifdef SPRITE_BORDER_EN
    bord = 1'b0;
`endif
    // Walk from highest index down so the lowest covering index is the last writer.
    for (int k = NUM_SPRITES - 1; k >= 0; k--) begin
      x1 = $signed(i_rects[k*4*COORD_W +: COORD_W]);
      x2 = $signed(i_rects[k*4*COORD_W + COORD_W +: COORD_W]);
      y1 = $signed(i_rects[k*4*COORD_W + 2*COORD_W +: COORD_W]);
      y2 = $signed(i_rects[k*4*COORD_W + 3*COORD_W +: COORD_W]);
      cov[k] = i_enable[k] && px > x1 && px < x2 && py > y1 && py < y2;
`ifdef SPRITE_BORDER_EN
      if (cov[k])
        bord = (px - x1 == COORD_W'(1)) || (x2 - px == COORD_W'(1)) ||
               (py - y1 == COORD_W'(1)) || (y2 - py == COORD_W'(1));
`endif
    end
    win_col = BG_COLOR;
    for (int k = NUM_SPRITES - 1; k >= 0; k--)
      if (hit_q[k]) win_col = i_colors[k*COLOR_W +: COLOR_W];
`ifdef SPRITE_BORDER_EN
    if (edge_q && |hit_q) win_col = BORDER_COLOR;
`endif
    // Bit 0 is always excluded so the player can never collide with itself.
    coll = i_pix_stb && hit_q[0] && |(hit_q & COLLIDE_MASK & ~NUM_SPRITES'(1)) && !blank_q;
    frame_hit = sticky_q || coll;
    hit_d = i_pix_stb ? cov : hit_q;
    blank_d = i_pix_stb ? i_blank : blank_q;
`ifdef SPRITE_BORDER_EN
    edge_d = i_pix_stb ? bord : edge_q;
`endif
    color_d = !i_pix_stb ? color_q : blank_q ? '0 : win_col;
    valid_d = i_pix_stb;
    sticky_d = !i_animate && frame_hit;
    collide_d = i_animate ? frame_hit : collide_q;
    cnt_d = (i_animate && frame_hit && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hit_q <= '0;
      blank_q <= 1'b0;
`ifdef SPRITE_BORDER_EN
      edge_q <= 1'b0;
`endif
      color_q <= BG_COLOR;
      valid_q <= 1'b0;
      sticky_q <= 1'b0;
      collide_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      hit_q <= hit_d;
      blank_q <= blank_d;
`ifdef SPRITE_BORDER_EN
      edge_q <= edge_d;
`endif
      color_q <= color_d;
      valid_q <= valid_d;
      sticky_q <= sticky_d;
      collide_q <= collide_d;
      cnt_q <= cnt_d;
    end
  end
  assign o_color = color_q;
  assign o_valid = valid_q;
  assign o_collide = collide_q;
  assign o_collide_cnt = cnt_q;
endmodule

// File: tb/tb_sprite_compositor.sv
// tb_sprite_compositor: directed vector and sequence bench for sprite_compositor
module tb_sprite_compositor;
  logic i_clk = 1'b0, i_rst = 1'b1, i_pix_stb = 1'b0, i_animate = 1'b0, i_blank = 1'b0;
  logic [9:0] i_x = '0;
  logic [8:0] i_y = '0;
  logic [191:0] i_rects = '0;
  logic [31:0] i_colors = {8'h03, 8'h92, 8'h1C, 8'hE0};
  logic [3:0] i_enable = '0;
  logic [7:0] o_color, o_collide_cnt;
  logic o_valid, o_collide;
  int checks = 0, errors = 0;

  sprite_compositor dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_pix_stb(i_pix_stb), .i_animate(i_animate), .i_blank(i_blank),
    .i_x(i_x), .i_y(i_y), .i_rects(i_rects), .i_colors(i_colors), .i_enable(i_enable),
    .o_color(o_color), .o_valid(o_valid), .o_collide(o_collide), .o_collide_cnt(o_collide_cnt)
  );

  always #5 i_clk = ~i_clk;

`ifdef SPRITE_BORDER_EN
  localparam logic [7:0] edge_col = 8'hFF;
`else
  localparam logic [7:0] edge_col = 8'hE0;
`endif

  typedef struct {
    string name;
    logic [191:0] rects;
    logic [3:0] en;
    int x;
    int y;
    logic blank;
    logic [7:0] exp;
  } vec_t;
  vec_t tv[13];

  function automatic logic [47:0] mk(input int x1, input int x2, input int y1, input int y2);
    return {12'(y2), 12'(y1), 12'(x2), 12'(x1)};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clk1();
    @(posedge i_clk);
    #1;
  endtask

  task automatic strobe();
    i_pix_stb = 1'b1;
    clk1();
    i_pix_stb = 1'b0;
  endtask

  task automatic animate();
    i_animate = 1'b1;
    clk1();
    i_animate = 1'b0;
  endtask

  task automatic set_px(input int x, input int y, input logic b);
    i_x = 10'(x);
    i_y = 9'(y);
    i_blank = b;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    clk1();
    i_rst = 1'b0;
  endtask

  logic [47:0] off, r0, ovl;

  initial begin
    off = '0;
    r0 = mk(10, 20, 10, 20);
    ovl = mk(18, 30, 14, 16);
    tv[0]  = '{"in_s0",      {off, off, off, r0}, 4'b0001, 15, 15, 1'b0, 8'hE0};
    tv[1]  = '{"left_bound", {off, off, off, r0}, 4'b0001, 10, 15, 1'b0, 8'h00};
    tv[2]  = '{"corner_in",  {off, off, off, r0}, 4'b0001, 19, 19, 1'b0, edge_col};
    tv[3]  = '{"edge_x1p1",  {off, off, off, r0}, 4'b0001, 11, 15, 1'b0, edge_col};
    tv[4]  = '{"right_bound",{off, off, off, r0}, 4'b0001, 20, 15, 1'b0, 8'h00};
    tv[5]  = '{"prio_s0",    {off, off, mk(28, 40, 28, 40), mk(25, 35, 25, 35)}, 4'b0011, 30, 30, 1'b0, 8'hE0};
    tv[6]  = '{"prio_s1",    {off, off, mk(28, 40, 28, 40), mk(25, 35, 25, 35)}, 4'b0010, 30, 30, 1'b0, 8'h1C};
    tv[7]  = '{"neg_x1",     {off, off, mk(-5, 3, 10, 20), off}, 4'b0010, 0, 15, 1'b0, 8'h1C};
    tv[8]  = '{"blank",      {off, off, mk(-5, 3, 10, 20), off}, 4'b0010, 0, 15, 1'b1, 8'h00};
    tv[9]  = '{"neg_x2bound",{off, off, mk(-5, 3, 10, 20), off}, 4'b0010, 3, 15, 1'b0, 8'h00};
    tv[10] = '{"prio_s2",    {mk(50, 60, 50, 60), mk(50, 60, 50, 60), off, off}, 4'b1100, 55, 55, 1'b0, 8'h92};
    tv[11] = '{"only_s3",    {mk(50, 60, 50, 60), mk(50, 60, 50, 60), off, off}, 4'b1000, 55, 55, 1'b0, 8'h03};
    tv[12] = '{"all_off",    {mk(50, 60, 50, 60), mk(50, 60, 50, 60), off, off}, 4'b0000, 55, 55, 1'b0, 8'h00};

    repeat (2) clk1();
    i_rst = 1'b0;
    chk("rst_color", o_color, 8'h00);
    chk("rst_valid", o_valid, 0);
    chk("rst_collide", o_collide, 0);
    chk("rst_cnt", o_collide_cnt, 0);

    for (int i = 0; i < 13; i++) begin
      i_rects = tv[i].rects;
      i_enable = tv[i].en;
      set_px(tv[i].x, tv[i].y, tv[i].blank);
      strobe();
      strobe();
      chk({tv[i].name, "_color"}, o_color, tv[i].exp);
      chk({tv[i].name, "_valid"}, o_valid, 1);
      clk1();
      chk({tv[i].name, "_valid_drop"}, o_valid, 0);
      chk({tv[i].name, "_hold"}, o_color, tv[i].exp);
    end

    // collision at one pixel mid-frame, then a clean frame
    do_reset();
    i_rects = {off, ovl, off, r0};
    i_enable = 4'b0101;
    set_px(5, 5, 1'b0);
    strobe();
    strobe();
    set_px(19, 15, 1'b0);
    strobe();
    set_px(5, 5, 1'b0);
    strobe();
    chk("ovl_color", o_color, edge_col);
    strobe();
    chk("pre_anim_collide", o_collide, 0);
    animate();
    chk("frame1_collide", o_collide, 1);
    chk("frame1_cnt", o_collide_cnt, 1);
    repeat (3) strobe();
    animate();
    chk("frame2_collide", o_collide, 0);
    chk("frame2_cnt", o_collide_cnt, 1);

    // collision and animate in the same cycle close the same frame
    set_px(19, 15, 1'b0);
    strobe();
    set_px(5, 5, 1'b0);
    i_pix_stb = 1'b1;
    i_animate = 1'b1;
    clk1();
    i_pix_stb = 1'b0;
    i_animate = 1'b0;
    chk("same_cyc_collide", o_collide, 1);
    chk("same_cyc_cnt", o_collide_cnt, 2);
    animate();
    chk("after_same_collide", o_collide, 0);
    chk("after_same_cnt", o_collide_cnt, 2);

    // blanked overlap does not collide
    set_px(19, 15, 1'b1);
    strobe();
    set_px(5, 5, 1'b0);
    strobe();
    chk("blank_ovl_color", o_color, 8'h00);
    animate();
    chk("blank_collide", o_collide, 0);
    chk("blank_cnt", o_collide_cnt, 2);

    // reset mid-frame dominates strobe and animate
    set_px(19, 15, 1'b0);
    strobe();
    set_px(5, 5, 1'b0);
    strobe();
    i_rst = 1'b1;
    i_pix_stb = 1'b1;
    i_animate = 1'b1;
    clk1();
    i_rst = 1'b0;
    i_pix_stb = 1'b0;
    i_animate = 1'b0;
    chk("midrst_color", o_color, 8'h00);
    chk("midrst_valid", o_valid, 0);
    animate();
    chk("midrst_collide", o_collide, 0);
    chk("midrst_cnt", o_collide_cnt, 0);
    chk("midrst_color2", o_color, 8'h00);

    // every cycle closes a colliding frame once the pipeline holds the overlap
    set_px(19, 15, 1'b0);
    i_pix_stb = 1'b1;
    i_animate = 1'b1;
    repeat (11) @(posedge i_clk);
    #1;
    chk("sat_partial_cnt", o_collide_cnt, 10);
    repeat (250) @(posedge i_clk);
    #1;
    i_pix_stb = 1'b0;
    i_animate = 1'b0;
    chk("sat_cnt", o_collide_cnt, 255);
    chk("sat_collide", o_collide, 1);
    animate();
    chk("sat_hold_cnt", o_collide_cnt, 255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sprite_compositor.md
Name: sprite_compositor

Overview:
- Parametrised successor to the fixed cactus/bird/floor/dino colour OR-mux in the top level.
- Takes NUM_SPRITES rectangles with per-sprite colours, resolves overlaps by fixed priority in a 2-stage pipeline, and drives the 8-bit RRRGGGBB pixel.
- Detects per-frame collisions between sprite 0 (dino) and a masked set of other sprites, reported once per frame on the animate pulse.
- Sits between the object modules (obstacle/dinosaur) and the VGA output pins.

Parameters:
- NUM_SPRITES, 4, number of rectangles; index 0 is the player, lower index = higher priority.
- COORD_W, 12, signed width of rectangle bounds.
- COLOR_W, 8, pixel colour width (RRRGGGBB).
- BG_COLOR, 8'h00, colour when no sprite covers the pixel.
- COLLIDE_MASK, all ones except bit 0, bit i set = sprite i can collide with sprite 0.
- CNT_W, 8, width of the collision frame counter.

Ports:
- i_clk  in  1  system clock (100 MHz).
- i_rst  in  1  synchronous active-high reset.
- i_pix_stb  in  1  pixel strobe; the pipeline advances only when high.
- i_animate  in  1  one-clock end-of-frame pulse.
- i_blank  in  1  pixel outside the active area; pipelined alongside x/y.
- i_x  in  10  current pixel x, unsigned.
- i_y  in  9  current pixel y, unsigned.
- i_rects  in  NUM_SPRITES*4*COORD_W  packed {y2,y1,x2,x1} per sprite; sprite i at slice i.
- i_colors  in  NUM_SPRITES*COLOR_W  packed colour per sprite.
- i_enable  in  NUM_SPRITES  per-sprite visible/collidable enable.
- o_color  out  COLOR_W  composited pixel colour.
- o_valid  out  1  high for one clock when o_color updates.
- o_collide  out  1  collision flag for the last completed frame.
- o_collide_cnt  out  CNT_W  count of frames containing a collision.

Behaviour:
- Reset values:
  - o_color = BG_COLOR; o_valid = 0; o_collide = 0; o_collide_cnt = 0.
  - Pipeline registers, hit vector and sticky collision bit all cleared.
  - Reset dominates all other inputs in the same cycle.
- Coverage test: zero-extend x/y to COORD_W, then compare signed. Sprite i covers the pixel iff i_enable[i] & x>x1 & x<x2 & y>y1 & y<y2 (strict). Negative bounds are legal (partially off-screen sprites).
- Stage 1, on a clock with i_pix_stb=1: register hit[NUM_SPRITES-1:0] and blank_d1.
- Stage 2, on the next clock with i_pix_stb=1:
  - o_color = colour of the lowest set index in hit; BG_COLOR if hit is 0; 0 if blank_d1.
  - o_valid pulses high.
- Latency: exactly 2 pix_stb strobes from input pixel to o_color. o_color holds between strobes.
- Collision:
  - Sticky bit sets on a stage-1 strobe when hit[0] & |(hit & COLLIDE_MASK) & !blank_d1.
  - On i_animate: o_collide <= sticky (or the collision from this same cycle); sticky clears.
  - If a collision and i_animate occur in the same cycle, the collision counts toward the frame being closed.
  - o_collide_cnt increments on i_animate when that frame had a collision, and saturates at all ones (no wrap).
- Simultaneous i_pix_stb and i_animate: both take effect.
- Reset mid-frame: sticky bit is discarded; the next frame starts clean.
- NUM_SPRITES=1: no collisions are possible; o_collide stays 0.

Optional Feature:
- Macro SPRITE_BORDER_EN.
- Defined:
  - Adds parameter BORDER_COLOR (default 8'hFF).
  - A covered pixel of the winning sprite with x==x1+1, x==x2-1, y==y1+1 or y==y2-1 is drawn in BORDER_COLOR. An edge flag is registered in stage 1 alongside hit.
  - Latency is unchanged.
- Not defined: winning pixels always use the sprite colour; no extra logic.

Test Plan:
- Sprite0 rect (10,20,10,20), colour 8'hE0, enabled; pixel (15,15) strobed → o_color=8'hE0 two strobes later. Pixel (10,15) (on the bound) → BG_COLOR.
- Sprite0 and sprite1 both cover (30,30), colours 8'hE0/8'h1C → o_color=8'hE0. Disable sprite0 → 8'h1C.
- Sprite1 x1=-5, x2=3, y covering pixel (0,y) → sprite1 colour shown. i_blank=1 on the same pixel → o_color=0.
- Sprite0 overlaps sprite2 at one pixel mid-frame, then i_animate → o_collide=1, o_collide_cnt=1. Next frame with no overlap, then i_animate → o_collide=0, count stays 1.
- Collision pixel and i_animate in the same cycle → counted toward the closing frame. Force 256 collision frames with CNT_W=8 → o_collide_cnt saturates at 255.
- Assert i_rst mid-frame after an overlap, then i_animate → o_collide=0, count=0, o_color=BG_COLOR. With SPRITE_BORDER_EN, pixel (11,15) in sprite0 → 8'hFF.
